// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory address, tracks the
// single outstanding request, and buffers returned words in a small FIFO that
// feeds decode through a valid/ready handshake. Redirects flush everything.

// One fetch-buffer slot holding {insn, pc}; data only, so no reset is needed.
module fetch_buf_entry (
    input  logic        clock,
    input  logic        wr_en,
    input  logic [31:0] insn_d,
    input  logic [31:0] pc_d,
    output logic [31:0] insn_q,
    output logic [31:0] pc_q
);

    // Capture the returned word and its PC when this slot is the tail
    always_ff @(posedge clock) begin
        if (wr_en) begin
            insn_q <= insn_d;
            pc_q   <= pc_d;
        end
    end

endmodule

module fetch_stage #(
    parameter int FIFO_DEPTH = 2   // pointer arithmetic below assumes exactly 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [11:0] address_imem,
    input  logic [31:0] q_imem,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [31:0] fd_insn,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_pc_plus_1
);

    localparam int PTR_W = 1;

    logic [31:0]                 pc;
    logic [31:0]                 req_pc;
    logic                        inflight;
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;
    logic [1:0]                  count;

    logic                        pop;
    logic                        push;
    logic                        issue;
    logic [2:0]                  credit;

    logic [FIFO_DEPTH-1:0][31:0] ent_insn;
    logic [FIFO_DEPTH-1:0][31:0] ent_pc;

    // Handshake and credit accounting. An issue is only allowed when the
    // buffer can absorb every word already owed to it plus the new one, so a
    // returning word always finds a free slot.
    assign fd_valid = (count != 2'd0);
    assign pop      = fd_valid && fd_ready;
    assign push     = inflight && !redirect_valid;
    assign credit   = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
    assign issue    = !redirect_valid && (credit < 3'd2);

    // Memory address follows pc every cycle; data for non-issued cycles is
    // simply never captured because inflight stays low.
    assign address_imem = pc[11:0];

    // Fetch pointer and in-flight tracking; redirect drops the pending word
    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= 32'd0;
            inflight <= 1'b0;
            req_pc   <= 32'd0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else if (issue) begin
            pc       <= pc + 32'd1;
            inflight <= 1'b1;
            req_pc   <= pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; a flush wins over any push or pop
    always_ff @(posedge clock) begin
        if (reset || redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Buffer slots; write enable decoded from the tail pointer
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_ent
        localparam logic [PTR_W-1:0] IDX = PTR_W'(i);
        fetch_buf_entry u_ent (
            .clock  (clock),
            .wr_en  (push && !reset && (tail == IDX)),
            .insn_d (q_imem),
            .pc_d   (req_pc),
            .insn_q (ent_insn[i]),
            .pc_q   (ent_pc[i])
        );
    end

    // Head entry drives decode; all outputs come from registers, not q_imem
    assign fd_insn      = ent_insn[head];
    assign fd_pc        = ent_pc[head];
    assign fd_pc_plus_1 = ent_pc[head] + 32'd1;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle-by-cycle stimulus with timing checks,
// plus a scoreboard of the expected accepted-instruction stream that a
// separate monitor pops on every decode transfer.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fd_valid;
    logic        fd_ready;
    logic [31:0] fd_insn;
    logic [31:0] fd_pc;
    logic [31:0] fd_pc_plus_1;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    fetch_stage #(.FIFO_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .address_imem   (address_imem),
        .q_imem         (q_imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fd_valid       (fd_valid),
        .fd_ready       (fd_ready),
        .fd_insn        (fd_insn),
        .fd_pc          (fd_pc),
        .fd_pc_plus_1   (fd_pc_plus_1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous instruction memory: word at address a is 0x1000 + a
    always @(posedge clock) q_imem <= 32'h1000 + {20'd0, address_imem};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every accepted transfer must match the next expected PC
    always @(negedge clock) begin
        if (!reset && fd_valid && fd_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", fd_pc, 32'hDEAD_BEEF);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                chk("sb_pc", fd_pc, e);
                chk("sb_insn", fd_insn, 32'h1000 + {20'd0, e[11:0]});
                chk("sb_pc_plus_1", fd_pc_plus_1, e + 32'd1);
            end
        end
    end

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; fd_ready = 1'b0;

        // Accepted stream, in order, for the whole run
        for (int i = 0; i <= 6; i++) exp_q.push_back(32'(i));
        for (int i = 32'h40; i <= 32'h44; i++) exp_q.push_back(32'(i));
        exp_q.push_back(32'h5);
        for (int i = 32'h80; i <= 32'h82; i++) exp_q.push_back(32'(i));
        exp_q.push_back(32'hFFFF_FFFF);
        for (int i = 0; i <= 2; i++) exp_q.push_back(32'(i));
        for (int i = 0; i <= 5; i++) exp_q.push_back(32'(i));

        // Reset state
        repeat (3) step();
        chk("rst_valid", {31'd0, fd_valid}, 32'd0);
        chk("rst_addr", {20'd0, address_imem}, 32'd0);

        // Free run: first issue in cycle 0, fd_valid in cycle 2
        reset = 1'b0; fd_ready = 1'b1;                 // cycle 0
        chk("c0_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // cycle 1
        chk("c1_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // cycle 2
        chk("c2_valid", {31'd0, fd_valid}, 32'd1);
        chk("c2_pc", fd_pc, 32'd0);
        repeat (3) step();                             // cycle 5

        // Stall five cycles on pc 3: head holds, fetch pointer parks at 5
        fd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin              // cycles 5..9
            chk("stall_pc", fd_pc, 32'd3);
            chk("stall_insn", fd_insn, 32'h1003);
            chk("stall_addr", {20'd0, address_imem}, 32'd5);
            step();
        end
        fd_ready = 1'b1;                               // cycle 10
        chk("release_pc", fd_pc, 32'd3);
        repeat (4) step();                             // cycle 14

        // Fill buffer with pc 7 and 8, then redirect to 0x40
        chk("fill_pc", fd_pc, 32'd7);
        fd_ready = 1'b0;
        step();                                        // cycle 15 (t)
        chk("full_pc", fd_pc, 32'd7);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();                                        // t+1
        redirect_valid = 1'b0; fd_ready = 1'b1;
        chk("rd_t1_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // t+2
        chk("rd_t2_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // t+3 (cycle 18)
        chk("rd_t3_valid", {31'd0, fd_valid}, 32'd1);
        chk("rd_t3_pc", fd_pc, 32'h40);
        step();
        chk("rd_t4_pc", fd_pc, 32'h41);
        repeat (3) step();                             // cycle 22

        // Redirect to 5 coincident with accepting 0x44
        chk("co_pc", fd_pc, 32'h44);
        redirect_valid = 1'b1; redirect_pc = 32'h5;
        step();                                        // cycle 23
        redirect_valid = 1'b0;
        chk("co_t1_valid", {31'd0, fd_valid}, 32'd0);
        step();
        chk("co_t2_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // cycle 25 (t)

        // Accept pc 5 under a redirect to 0x40, then redirect again to 0x80
        chk("b2b_pc5", fd_pc, 32'h5);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();                                        // t+1
        redirect_pc = 32'h80;
        chk("b2b_t1_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // t+2
        redirect_valid = 1'b0;
        chk("b2b_t2_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // t+3
        chk("b2b_t3_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // t+4 (cycle 29)
        chk("b2b_t4_pc", fd_pc, 32'h80);
        repeat (2) step();                             // cycle 31

        // Wrap through 0xFFFFFFFF
        chk("wrap_pre_pc", fd_pc, 32'h82);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        repeat (2) step();                             // cycle 34
        chk("wrap_pc", fd_pc, 32'hFFFF_FFFF);
        chk("wrap_plus1", fd_pc_plus_1, 32'h0);
        chk("wrap_insn", fd_insn, 32'h1FFF);
        step();                                        // cycle 35
        chk("wrap_next_pc", fd_pc, 32'h0);
        repeat (3) step();                             // cycle 38

        // Fill buffer, then reset mid-operation
        chk("prerst_pc", fd_pc, 32'd3);
        fd_ready = 1'b0;
        step();                                        // cycle 39
        chk("prerst_valid", {31'd0, fd_valid}, 32'd1);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h123;
        step();                                        // cycle 40
        chk("midrst_valid", {31'd0, fd_valid}, 32'd0);
        chk("midrst_addr", {20'd0, address_imem}, 32'd0);
        step();                                        // cycle 41
        reset = 1'b0; redirect_valid = 1'b0; fd_ready = 1'b1;
        chk("post_c0_valid", {31'd0, fd_valid}, 32'd0);
        step();
        chk("post_c1_valid", {31'd0, fd_valid}, 32'd0);
        step();                                        // cycle 43
        chk("post_c2_pc", fd_pc, 32'd0);
        repeat (5) step();                             // cycle 48
        chk("post_pc5", fd_pc, 32'd5);
        step();
        fd_ready = 1'b0;
        repeat (3) step();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
